// File: rtl/signed_sort_ctrl_if.sv
// Handshake bundle for signed_sort_ctrl: the sample input stream and the sorted output stream.
interface signed_sort_ctrl_if #(parameter int W = 5);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/signed_sort_ctrl.sv
// In-place bubble sort of an N-sample signed burst using one shared comparator.
// Define SIGNED_SORT_DESCEND_EN to emit the burst in descending instead of ascending order.
module signed_sort_ctrl #(
  parameter int N = 8,
  parameter int W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  signed_sort_ctrl_if.slave     ss,
  output logic                  busy
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_CMP = IW'(N - 2);
  localparam logic [IW-1:0] LAST_OUT = IW'(N - 1);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t        state, state_n;
  logic [W-1:0]  mem [N];
  logic [IW-1:0] idx, idx_p1, pass;
  logic          swapped;
  logic [W-1:0]  lo_val, hi_val;
  logic          swap, pass_end, sort_done;
  logic          in_ready, out_valid, out_last;
  logic [W-1:0]  out_data;

  // Mixed signs: the negative operand is smaller; same sign: the wrapped difference cannot overflow.
  function automatic logic slt(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    if (a[W-1] != b[W-1]) return a[W-1];
    d = a + (~b + W'(1));
    return d[W-1];
  endfunction

  assign idx_p1 = idx + IW'(1);
  assign lo_val = mem[idx];
  assign hi_val = mem[idx_p1];

`ifdef SIGNED_SORT_DESCEND_EN
  assign swap = slt(lo_val, hi_val);
`else
  assign swap = slt(hi_val, lo_val);
`endif

  assign pass_end  = (idx == LAST_CMP);
  assign sort_done = pass_end && (!(swapped || swap) || pass == LAST_CMP);

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (ss.in_valid && idx == LAST_OUT) state_n = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (sort_done) state_n = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = mem[idx];
        out_last  = (idx == LAST_OUT);
        if (ss.out_ready && out_last) state_n = LOAD;
      end
      default: state_n = LOAD;
    endcase
  end

  assign ss.in_ready  = in_ready;
  assign ss.out_valid = out_valid;
  assign ss.out_last  = out_last;
  assign ss.out_data  = out_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      pass    <= '0;
      swapped <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (ss.in_valid) begin
            mem[idx] <= ss.in_data;
            if (idx == LAST_OUT) begin
              idx     <= '0;
              pass    <= '0;
              swapped <= 1'b0;
            end else begin
              idx <= idx_p1;
            end
          end
        end
        SORT: begin
          if (swap) begin
            mem[idx]    <= hi_val;
            mem[idx_p1] <= lo_val;
            swapped     <= 1'b1;
          end
          if (pass_end) begin
            idx <= '0;
            if (!sort_done) begin
              pass    <= pass + IW'(1);
              swapped <= 1'b0;
            end
          end else begin
            idx <= idx_p1;
          end
        end
        DRAIN: begin
          if (ss.out_ready) idx <= (idx == LAST_OUT) ? '0 : idx_p1;
        end
        default: idx <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_sort_ctrl.sv
// Directed-vector bench for signed_sort_ctrl with hand-computed expected sort results.
module tb_signed_sort_ctrl;
  localparam int N = 8;
  localparam int W = 5;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  signed_sort_ctrl_if #(.W(W)) ss ();

  signed_sort_ctrl #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .ss    (ss),
    .busy  (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int sdata();
    logic signed [W-1:0] v;
    v = signed'(ss.out_data);
    return int'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a[N], input logic [N-1:0] gap);
    for (int i = 0; i < N; i++) begin
      if (gap[i]) begin
        ss.in_valid = 1'b0;
        ss.in_data  = '1;
        step();
      end
      ss.in_valid = 1'b1;
      ss.in_data  = a[i][W-1:0];
      check($sformatf("load%0d_ready", i), int'(ss.in_ready), 1);
      step();
    end
    ss.in_valid = 1'b0;
  endtask

  task automatic sort_wait(input int exp_cycles);
    int cnt;
    cnt = 0;
    check("sort_busy", int'(busy), 1);
    check("sort_in_ready", int'(ss.in_ready), 0);
    while (!ss.out_valid && cnt < 500) begin
      step();
      cnt++;
    end
    check("sort_done", int'(ss.out_valid), 1);
    if (exp_cycles >= 0) check("sort_cycles", cnt, exp_cycles);
  endtask

  task automatic drain(input int e[N], input int stall_at, input int stall_n);
    int held;
    ss.out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i == stall_at) begin
        ss.out_ready = 1'b0;
        held = sdata();
        for (int k = 0; k < stall_n; k++) begin
          step();
          check("stall_valid", int'(ss.out_valid), 1);
          check("stall_data", sdata(), held);
        end
        ss.out_ready = 1'b1;
      end
      check($sformatf("beat%0d_valid", i), int'(ss.out_valid), 1);
      check($sformatf("beat%0d_data", i), sdata(), e[i]);
      check($sformatf("beat%0d_last", i), int'(ss.out_last), (i == N - 1) ? 1 : 0);
      step();
    end
    ss.out_ready = 1'b0;
    check("post_valid", int'(ss.out_valid), 0);
    check("post_in_ready", int'(ss.in_ready), 1);
    check("post_busy", int'(busy), 0);
  endtask

  initial begin
    int rev_in[N]  = '{15, 10, 5, 0, -1, -6, -11, -16};
    int rev_out[N] = '{-16, -11, -6, -1, 0, 5, 10, 15};
    int srt[N]     = '{-16, -8, -1, 0, 1, 2, 8, 15};
    int bnd_in[N]  = '{0, -16, 15, -16, 3, 3, -1, 0};
    int bnd_out[N] = '{-16, -16, -1, 0, 0, 3, 3, 15};
    int sev[N]     = '{7, 7, 7, 7, 7, 7, 7, 7};
    int asc_in[N]  = '{-16, -15, -14, -13, -12, -11, -10, -9};
    int dsc_out[N] = '{-9, -10, -11, -12, -13, -14, -15, -16};

    reset = 1'b1;
    ss.in_valid  = 1'b0;
    ss.in_data   = '0;
    ss.out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_in_ready", int'(ss.in_ready), 1);
    check("rst_out_valid", int'(ss.out_valid), 0);
    check("rst_out_last", int'(ss.out_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_data", int'(ss.out_data), 0);

`ifdef SIGNED_SORT_DESCEND_EN
    load(asc_in, '0);
    sort_wait(49);
    drain(dsc_out, -1, 0);
`else
    load(rev_in, '0);
    sort_wait(49);
    drain(rev_out, -1, 0);

    load(srt, 8'b1010_0101);
    sort_wait(7);
    drain(srt, -1, 0);

    load(bnd_in, '0);
    sort_wait(-1);
    drain(bnd_out, 3, 5);

    load(rev_in, '0);
    repeat (16) step();
    check("mid_sort_busy", int'(busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_in_ready", int'(ss.in_ready), 1);
    check("abort_out_valid", int'(ss.out_valid), 0);
    check("abort_busy", int'(busy), 0);
    load(sev, '0);
    sort_wait(7);
    drain(sev, -1, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
